// File: rtl/float_norm_round.sv
`default_nettype none
// ============================================================================
// Module      : float_norm_round
// Description : Normalise and round a raw single-precision sum to an
//               IEEE-754 binary32 result. One operation in flight; the
//               significand is normalised one left shift per clock, then
//               rounded to nearest-even in a single ROUND cycle.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   FLUSH_DENORM : 0 = produce denormal results, 1 = flush them to signed zero
// Ports
//   clk       in   1  clock, rising edge
//   rst_n     in   1  asynchronous active-low reset
//   in_valid  in   1  raw sum present
//   in_ready  out  1  block idle and able to accept
//   in_sign   in   1  sign of raw sum
//   in_exp    in   8  biased exponent for bit 26 of in_mant
//   in_mant   in  28  [27] carry-out, [26] hidden, [25:3] fraction,
//                     [2] guard, [1] round, [0] sticky
//   out_valid out  1  result present
//   out_ready in   1  consumer accepts result
//   out_sum   out 32  IEEE-754 single result
//   out_flags out  3  {overflow, underflow, inexact}
// ============================================================================
module float_norm_round #(
    parameter int FLUSH_DENORM = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [7:0]  in_exp,
    input  logic [27:0] in_mant,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_sum,
    output logic [2:0]  out_flags
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_NORM  = 2'd1;
    localparam logic [1:0] S_ROUND = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [8:0] c_EXP_MAX = 9'd255;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]  r_state;
    logic        r_sign;
    logic [7:0]  r_exp;
    logic [27:0] r_mant;
    logic        r_special;     // operand captured with exponent 255
    logic [31:0] r_out_sum;
    logic [2:0]  r_out_flags;

    // ------------------------------------------------------------------------
    // Rounding datapath (evaluated from the normalised mantissa)
    // ------------------------------------------------------------------------
    logic        w_lsb;
    logic        w_guard;
    logic        w_rs;
    logic        w_inc;
    logic        w_inexact;
    logic        w_mant_zero;
    logic [24:0] w_sig_rnd;
    logic [8:0]  w_exp_rnd;
    logic [31:0] w_res_sum;
    logic [2:0]  w_res_flags;

    assign w_lsb       = r_mant[3];
    assign w_guard     = r_mant[2];
    assign w_rs        = r_mant[1] | r_mant[0];
    assign w_inc       = w_guard & (w_rs | w_lsb);
    assign w_inexact   = w_guard | w_rs;
    assign w_mant_zero = (r_mant == 28'd0);

    // 25-bit sum so a carry out of the 24-bit significand is visible in
    // bit 24 (normal) or a denormal promotion is visible in bit 23.
    assign w_sig_rnd = {1'b0, r_mant[26:3]} + {24'd0, w_inc};
    assign w_exp_rnd = {1'b0, r_exp} + {8'd0, w_sig_rnd[24]};

    always_comb begin
        w_res_sum   = 32'd0;
        w_res_flags = 3'b000;
        if (r_special) begin
            // Infinity / NaN passthrough: exponent forced, fraction kept.
            w_res_sum   = {r_sign, 8'hFF, r_mant[25:3]};
            w_res_flags = 3'b000;
        end else if (w_mant_zero) begin
            w_res_sum   = {r_sign, 31'd0};
            w_res_flags = 3'b000;
        end else if (r_mant[26]) begin
            // Normal result. Also catches an exponent already at 255 after
            // the carry-out right shift.
            if (w_exp_rnd >= c_EXP_MAX) begin
                w_res_sum   = {r_sign, 8'hFF, 23'd0};
                w_res_flags = 3'b101;
            end else if (w_sig_rnd[24]) begin
                // Significand rounded up to 2.0: becomes 1.0 at exp+1.
                w_res_sum   = {r_sign, w_exp_rnd[7:0], 23'd0};
                w_res_flags = {2'b00, w_inexact};
            end else begin
                w_res_sum   = {r_sign, w_exp_rnd[7:0], w_sig_rnd[22:0]};
                w_res_flags = {2'b00, w_inexact};
            end
        end else begin
            // Hidden bit still clear after normalisation: denormal.
            if (FLUSH_DENORM != 0) begin
                w_res_sum   = {r_sign, 31'd0};
                w_res_flags = 3'b011;
            end else begin
                // Rounding into bit 26 promotes to the smallest normal,
                // which is exactly exponent field 1 with the same fraction.
                w_res_sum   = {r_sign, 7'd0, w_sig_rnd[23], w_sig_rnd[22:0]};
                w_res_flags = {1'b0, w_inexact, w_inexact};
            end
        end
    end

    // ------------------------------------------------------------------------
    // Control FSM and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_sign      <= 1'b0;
            r_exp       <= 8'd0;
            r_mant      <= 28'd0;
            r_special   <= 1'b0;
            r_out_sum   <= 32'd0;
            r_out_flags <= 3'b000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_sign    <= in_sign;
                        r_exp     <= in_exp;
                        r_mant    <= in_mant;
                        r_special <= (in_exp == 8'hFF);
                        r_state   <= S_NORM;
                    end
                end

                S_NORM: begin
                    if (r_special) begin
                        r_state <= S_ROUND;
                    end else if (r_mant[27]) begin
                        // Right shift folds the two lost-side bits into the
                        // new sticky so no inexactness is dropped.
                        r_mant  <= {1'b0, r_mant[27:2], r_mant[1] | r_mant[0]};
                        r_exp   <= r_exp + 8'd1;
                        r_state <= S_ROUND;
                    end else if (w_mant_zero) begin
                        r_state <= S_ROUND;
                    end else if (!r_mant[26] && (r_exp > 8'd1)) begin
                        r_mant <= {r_mant[26:0], 1'b0};
                        r_exp  <= r_exp - 8'd1;
                    end else begin
                        r_state <= S_ROUND;
                    end
                end

                S_ROUND: begin
                    r_out_sum   <= w_res_sum;
                    r_out_flags <= w_res_flags;
                    r_state     <= S_DONE;
                end

                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign out_sum   = r_out_sum;
    assign out_flags = r_out_flags;

endmodule
`default_nettype wire

// File: tb/tb_float_norm_round.sv
`default_nettype none
// ============================================================================
// Module      : tb_float_norm_round
// Description : Scoreboard bench for float_norm_round. Two instances share
//               stimulus: one with denormals kept, one with denormals flushed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_float_norm_round;

    typedef struct {
        logic [31:0] sum;
        logic [2:0]  flags;
        int          k;
    } exp_t;

    typedef struct {
        exp_t keep;
        exp_t flush;
    } sb_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [27:0] in_mant;
    logic        out_ready;

    logic        in_ready,   in_ready_f;
    logic        out_valid,  out_valid_f;
    logic [31:0] out_sum,    out_sum_f;
    logic [2:0]  out_flags,  out_flags_f;

    int n_checks;
    int n_fail;
    sb_t sb[$];

    float_norm_round #(.FLUSH_DENORM(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_flags(out_flags)
    );

    float_norm_round #(.FLUSH_DENORM(1)) dut_f (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready_f),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
        .out_valid(out_valid_f), .out_ready(out_ready),
        .out_sum(out_sum_f), .out_flags(out_flags_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got,
                             input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=0x%0h want=0x%0h", tag, got, want);
        end
    endtask

    // Reference: normalise by counting leading zeros, then round-half-even.
    function automatic exp_t model(input logic s, input logic [7:0] ex,
                                   input logic [27:0] mn, input bit flush);
        exp_t        r;
        logic [27:0] m;
        int          e;
        logic [24:0] sig;
        bit          inx;
        bit          rup;
        r.k = 0;
        r.sum = 32'd0;
        r.flags = 3'b000;
        if (ex == 8'hFF) begin
            r.sum = {s, 8'hFF, mn[25:3]};
            return r;
        end
        if (mn == 28'd0) begin
            r.sum = {s, 31'd0};
            return r;
        end
        m = mn;
        e = int'(ex);
        if (m[27]) begin
            m = {1'b0, m[27:1]} | {27'd0, mn[0]};
            e = e + 1;
        end else begin
            while (!m[26] && e > 1) begin
                m = m << 1;
                e = e - 1;
                r.k = r.k + 1;
            end
        end
        if (e >= 255) begin
            r.sum = {s, 8'hFF, 23'd0};
            r.flags = 3'b101;
            return r;
        end
        inx = (m[2:0] != 3'd0);
        rup = m[2] && ((m[1:0] != 2'd0) || m[3]);
        sig = {1'b0, m[26:3]} + (rup ? 25'd1 : 25'd0);
        if (m[26]) begin
            if (sig[24]) begin
                sig = 25'h0800000;
                e = e + 1;
            end
            if (e >= 255) begin
                r.sum = {s, 8'hFF, 23'd0};
                r.flags = 3'b101;
            end else begin
                r.sum = {s, 8'(e), sig[22:0]};
                r.flags = {2'b00, inx};
            end
        end else if (flush) begin
            r.sum = {s, 31'd0};
            r.flags = 3'b011;
        end else begin
            r.sum = {s, (sig[23] ? 8'd1 : 8'd0), sig[22:0]};
            r.flags = {1'b0, inx, inx};
        end
        return r;
    endfunction

    task automatic run_op(input logic s, input logic [7:0] ex,
                          input logic [27:0] mn, input bit stall);
        sb_t e0;
        sb_t got_e;
        int  n;
        int  lat;
        e0.keep  = model(s, ex, mn, 1'b0);
        e0.flush = model(s, ex, mn, 1'b1);
        sb.push_back(e0);
        @(negedge clk);
        in_valid = 1'b1;
        in_sign  = s;
        in_exp   = ex;
        in_mant  = mn;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check_val("accept_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
            void'(sb.pop_front());
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        got_e = sb.pop_front();
        if (!out_valid) begin
            check_val("result_timeout", 64'd0, 64'd1);
            return;
        end
        check_val("sum",         64'(out_sum),     64'(got_e.keep.sum));
        check_val("flags",       64'(out_flags),   64'(got_e.keep.flags));
        check_val("latency",     64'(lat),         64'(2 + got_e.keep.k));
        check_val("flush_valid", 64'(out_valid_f), 64'd1);
        check_val("flush_sum",   64'(out_sum_f),   64'(got_e.flush.sum));
        check_val("flush_flags", 64'(out_flags_f), 64'(got_e.flush.flags));
        if (stall) begin
            for (int i = 0; i < 10; i++) begin
                @(posedge clk);
                #1;
                check_val("stall_sum",   64'(out_sum),   64'(got_e.keep.sum));
                check_val("stall_ready", 64'(in_ready),  64'd0);
                check_val("stall_valid", 64'(out_valid), 64'd1);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_val("drain_valid", 64'(out_valid), 64'd0);
        check_val("drain_ready", 64'(in_ready),  64'd1);
    endtask

    initial begin
        logic [27:0] rm;
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = 8'd0;
        in_mant   = 28'd0;
        out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_val("rst_valid", 64'(out_valid), 64'd0);
        check_val("rst_sum",   64'(out_sum),   64'd0);
        check_val("rst_flags", 64'(out_flags), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("rst_ready", 64'(in_ready), 64'd1);

        // Directed vectors
        run_op(1'b0, 8'd127, 28'h4000000, 1'b0);
        run_op(1'b0, 8'd127, 28'h8000000, 1'b0);
        run_op(1'b0, 8'd130, 28'h0800000, 1'b0);
        run_op(1'b0, 8'd127, 28'h4000004, 1'b0);
        run_op(1'b0, 8'd127, 28'h400000C, 1'b0);
        run_op(1'b0, 8'd254, 28'h8000000, 1'b0);
        run_op(1'b0, 8'd1,   28'h0800000, 1'b0);
        run_op(1'b0, 8'd1,   28'h0800004, 1'b0);
        run_op(1'b1, 8'd100, 28'h0000000, 1'b0);
        run_op(1'b0, 8'd127, 28'h7FFFFFC, 1'b0);
        run_op(1'b0, 8'd254, 28'h7FFFFFF, 1'b0);
        run_op(1'b1, 8'd1,   28'h3FFFFFC, 1'b0);
        run_op(1'b0, 8'd255, 28'h2ABCDEF, 1'b0);
        run_op(1'b0, 8'd100, 28'h8000003, 1'b0);
        run_op(1'b0, 8'd30,  28'h0000001, 1'b0);
        run_op(1'b1, 8'd126, 28'h400001C, 1'b1);

        // Randomised operands with varied leading-zero counts
        for (int i = 0; i < 24; i++) begin
            rm = 28'($urandom) >> $urandom_range(0, 27);
            run_op(1'($urandom), 8'($urandom_range(0, 254)), rm, 1'b0);
        end

        // Reset in the middle of normalisation: no result may appear.
        @(negedge clk);
        in_valid = 1'b1;
        in_sign  = 1'b0;
        in_exp   = 8'd130;
        in_mant  = 28'h0800000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("abort_valid", 64'(out_valid), 64'd0);
        check_val("abort_sum",   64'(out_sum),   64'd0);
        check_val("abort_flags", 64'(out_flags), 64'd0);
        check_val("abort_ready", 64'(in_ready),  64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check_val("abort_no_late", 64'(out_valid | out_valid_f), 64'd0);
        end
        check_val("abort_ready_after", 64'(in_ready), 64'd1);

        // Block still functional after the abort.
        run_op(1'b0, 8'd127, 28'h4000000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
